// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the npc mux, issues
// single-outstanding imem reads and buffers instructions for decode.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, no request yet
// REQ   | presenting pc_q to imem (when aligned and decode can take data)
// WAIT  | one fetch outstanding, waiting for rvalid (kill marks wrong path)
// HOLD  | output buffer full and blocked, returned word parked in skid
// ERR   | misaligned fetch seen; terminal until reset
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_sel,
  input  logic [31:0] redirect_pc,
  input  logic [15:0] redirect_offset,
  input  logic [25:0] redirect_index,
  input  logic [31:0] redirect_reg,
  output logic [31:0] npc_pc,
  output logic [1:0]  npc_sel,
  output logic [15:0] npc_offset,
  output logic [25:0] npc_irrelative,
  output logic [31:0] npc_register,
  input  logic [31:0] npc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        fetch_err,
  output logic [31:0] err_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] fetch_pc;
  logic        kill;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        pc_aligned;
  logic        gnt_ok;

  // All PC arithmetic lives in npc; this block only selects what npc computes.
  always_comb begin
    npc_sel        = 2'd0;
    npc_pc         = pc_q;
    npc_offset     = 16'd0;
    npc_irrelative = 26'd0;
    npc_register   = 32'd0;
    if (redirect_valid) begin
      npc_sel        = redirect_sel;
      npc_pc         = redirect_pc;
      npc_offset     = redirect_offset;
      npc_irrelative = redirect_index;
      npc_register   = redirect_reg;
    end
  end

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign imem_req   = (state == S_REQ) && pc_aligned && (!if_valid || id_ready);
  assign imem_addr  = pc_q;
  assign gnt_ok     = imem_req && imem_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc   <= RESET_PC;
      kill       <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= 32'd0;
      if_pc      <= 32'd0;
      skid_valid <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      fetch_err  <= 1'b0;
      err_pc     <= 32'd0;
    end else begin
      // Redirect flushes the decode buffer; otherwise it drains on consume.
      if (redirect_valid && state != S_ERR)
        if_valid <= 1'b0;
      else if (id_ready)
        if_valid <= 1'b0;

      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (!pc_aligned) begin
            fetch_err <= 1'b1;
            err_pc    <= pc_q;
            state     <= S_ERR;
          end else if (gnt_ok) begin
            fetch_pc <= pc_q;
            pc_q     <= npc_next;
            kill     <= redirect_valid;
            state    <= S_WAIT;
          end else if (redirect_valid) begin
            pc_q <= npc_next;
          end
        end

        S_WAIT: begin
          if (redirect_valid) begin
            pc_q <= npc_next;
            kill <= 1'b1;
          end
          if (imem_rvalid) begin
            kill <= 1'b0;
            if (kill || redirect_valid) begin
              state <= S_REQ;
            end else if (!if_valid || id_ready) begin
              if_valid <= 1'b1;
              if_instr <= imem_rdata;
              if_pc    <= fetch_pc;
              state    <= S_REQ;
            end else begin
              skid_valid <= 1'b1;
              skid_instr <= imem_rdata;
              skid_pc    <= fetch_pc;
              state      <= S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            skid_valid <= 1'b0;
            pc_q       <= npc_next;
            state      <= S_REQ;
          end else if (id_ready && skid_valid) begin
            if_valid   <= 1'b1;
            if_instr   <= skid_instr;
            if_pc      <= skid_pc;
            skid_valid <= 1'b0;
            state      <= S_REQ;
          end
        end

        S_ERR: state <= S_ERR;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
